// File: rtl/sort_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort_seq_ctrl
// Purpose  : Flow controller between UART RX buffer, bitonic sorter and UART
//            TX buffer; tracks delivered, dropped and timed-out sequences.
// Revision : 1.0
// ============================================================================
module sort_seq_ctrl #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int NUM_SEQ     = 10,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid_i,
    input  logic [WIDTH*DEPTH-1:0]         in_array_i,
    output logic                           in_ready_o,
    output logic                           sort_start_o,
    output logic [WIDTH*DEPTH-1:0]         sort_array_o,
    input  logic                           sort_done_i,
    input  logic [WIDTH*DEPTH-1:0]         sort_result_i,
    input  logic                           tx_full_i,
    output logic                           tx_load_o,
    output logic [WIDTH*DEPTH-1:0]         tx_array_o,
    output logic                           busy_o,
    output logic [$clog2(NUM_SEQ+1)-1:0]   seq_count_o,
    output logic                           batch_done_o,
    output logic [7:0]                     drop_count_o,
    output logic                           timeout_err_o
);

    localparam int c_SEQ_W = $clog2(NUM_SEQ + 1);
    localparam int c_TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_SEQ_W-1:0] c_SEQ_LAST = c_SEQ_W'(NUM_SEQ - 1);
    localparam logic [c_SEQ_W-1:0] c_SEQ_ONE  = c_SEQ_W'(1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_TX = 3'd1,
        S_START   = 3'd2,
        S_SORTING = 3'd3,
        S_DELIVER = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH*DEPTH-1:0]   hold_q, hold_d;
    logic [WIDTH*DEPTH-1:0]   tx_array_q, tx_array_d;
    logic [c_TMO_W-1:0]       tmo_q, tmo_d;
    logic [c_SEQ_W-1:0]       seq_q, seq_d;
    logic [7:0]               drop_q, drop_d;
    logic                     terr_q, terr_d;

    // in_ready is forced low while reset is held so no capture is advertised
    assign in_ready_o    = (state_q == S_IDLE) && !rst;
    assign busy_o        = (state_q != S_IDLE);
    assign sort_array_o  = hold_q;
    assign tx_array_o    = tx_array_q;
    assign seq_count_o   = seq_q;
    assign drop_count_o  = drop_q;
    assign timeout_err_o = terr_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        tx_array_d   = tx_array_q;
        tmo_d        = tmo_q;
        seq_d        = seq_q;
        drop_d       = drop_q;
        terr_d       = terr_q;
        sort_start_o = 1'b0;
        tx_load_o    = 1'b0;
        batch_done_o = 1'b0;

        if (in_valid_i && !in_ready_o && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    hold_d  = in_array_i;
                    state_d = tx_full_i ? S_WAIT_TX : S_START;
                end
            end
            S_WAIT_TX: begin
                if (!tx_full_i) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                sort_start_o = 1'b1;
                tmo_d        = '0;
                state_d      = S_SORTING;
            end
            S_SORTING: begin
                tmo_d = tmo_q + c_TMO_ONE;
                // A result arriving on the last allowed cycle still counts
                if (sort_done_i) begin
                    tx_array_d = sort_result_i;
                    state_d    = S_DELIVER;
                end else if (tmo_q == c_TMO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DELIVER: begin
                tx_load_o = 1'b1;
                if (seq_q == c_SEQ_LAST) begin
                    seq_d        = '0;
                    batch_done_o = 1'b1;
                end else begin
                    seq_d = seq_q + c_SEQ_ONE;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            tx_array_q <= '0;
            tmo_q      <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tx_array_q <= tx_array_d;
            tmo_q      <= tmo_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            terr_q     <= terr_d;
        end
    end

endmodule
`default_nettype wire
